// File: rtl/lab3_mem_refill_arbiter.sv
// ----------------------------------------------------------------------------
// lab3_mem_refill_arbiter
//
// Shares one 16B memory port between two blocking caches (typically I$ on
// port 0, D$ on port 1). One requester is granted, its request is forwarded
// to memory, and the arbiter then locks onto that requester until the
// matching memory response has been handed back to it. Priority on
// contention is round-robin: after a transaction completes, the other port
// is favoured.
//
// Message layouts (flat vectors, fields MSB first):
//   mem_req_16B_t  [174:0] = {type[2:0], opaque[7:0], addr[31:0], len[3:0], data[127:0]}
//   mem_resp_16B_t [144:0] = {type[2:0], opaque[7:0], test[1:0], len[3:0], data[127:0]}
// Messages pass through unmodified, so the arbiter never decodes them.
//
// Ports:
//   clk                          clock, rising edge
//   reset                        asynchronous, active-low (0 = in reset)
//   reqN_msg/val/rdy    (N=0,1)  requester N request channel (in/in/out)
//   respN_msg/val/rdy   (N=0,1)  response channel to requester N (out/out/in)
//   memreq_msg/val/rdy           request channel to memory (out/out/in)
//   memresp_msg/val/rdy          response channel from memory (in/in/out)
// ----------------------------------------------------------------------------
module lab3_mem_refill_arbiter (
  input  logic         clk,
  input  logic         reset,

  input  logic [174:0] req0_msg,
  input  logic         req0_val,
  output logic         req0_rdy,
  output logic [144:0] resp0_msg,
  output logic         resp0_val,
  input  logic         resp0_rdy,

  input  logic [174:0] req1_msg,
  input  logic         req1_val,
  output logic         req1_rdy,
  output logic [144:0] resp1_msg,
  output logic         resp1_val,
  input  logic         resp1_rdy,

  output logic [174:0] memreq_msg,
  output logic         memreq_val,
  input  logic         memreq_rdy,

  input  logic [144:0] memresp_msg,
  input  logic         memresp_val,
  output logic         memresp_rdy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner;
  logic        r_prio;
  // Completed-transaction counter, kept for line tracing / debug only.
  logic [15:0] r_txn_cnt;

  logic        w_grant_any;
  logic        w_grant_sel;
  logic        w_req_fire;
  logic        w_resp_fire;

  // Combinational grant. prio only matters when both ports contend; with a
  // single requester the grant simply follows whichever val is high.
  always_comb begin
    w_grant_any = req0_val | req1_val;
    w_grant_sel = (req0_val & req1_val) ? r_prio : req1_val;
  end

  always_comb begin
    w_state_nxt = r_state;
    memreq_msg  = w_grant_sel ? req1_msg : req0_msg;
    memreq_val  = 1'b0;
    req0_rdy    = 1'b0;
    req1_rdy    = 1'b0;
    resp0_msg   = memresp_msg;
    resp1_msg   = memresp_msg;
    resp0_val   = 1'b0;
    resp1_val   = 1'b0;
    memresp_rdy = 1'b0;

    // Handshake outputs are gated by reset so that nothing can fire while
    // the block is held in reset, whatever the inputs are doing.
    if (reset) begin
      case (r_state)
        ST_IDLE: begin
          memreq_val = w_grant_any;
          req0_rdy   = w_grant_any & ~w_grant_sel & memreq_rdy;
          req1_rdy   = w_grant_any &  w_grant_sel & memreq_rdy;
          if (w_grant_any && memreq_rdy) begin
            w_state_nxt = ST_WAIT;
          end
        end
        ST_WAIT: begin
          // memresp_rdy depends only on the owner's resp_rdy, never on
          // either req_val, so the two directions stay decoupled.
          resp0_val   = memresp_val & ~r_owner;
          resp1_val   = memresp_val &  r_owner;
          memresp_rdy = r_owner ? resp1_rdy : resp0_rdy;
          if (memresp_val && memresp_rdy) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    w_req_fire  = memreq_val & memreq_rdy;
    w_resp_fire = memresp_val & memresp_rdy;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_owner   <= 1'b0;
      r_prio    <= 1'b0;
      r_txn_cnt <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_req_fire) begin
        r_owner <= w_grant_sel;
      end
      // Favour the other port next time so back-to-back contention alternates.
      if (w_resp_fire) begin
        r_prio    <= ~r_owner;
        r_txn_cnt <= r_txn_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_lab3_mem_refill_arbiter.sv
module tb_lab3_mem_refill_arbiter;

  localparam int REQ_W  = 175;
  localparam int RESP_W = 145;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              rq_val [2];
  logic [REQ_W-1:0]  rq_msg [2];
  logic              rs_rdy [2];
  logic              req0_rdy, req1_rdy;
  logic [RESP_W-1:0] resp0_msg, resp1_msg;
  logic              resp0_val, resp1_val;
  logic [REQ_W-1:0]  memreq_msg;
  logic              memreq_val, memreq_rdy;
  logic [RESP_W-1:0] memresp_msg;
  logic              memresp_val, memresp_rdy;

  lab3_mem_refill_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_msg   (rq_msg[0]),
    .req0_val   (rq_val[0]),
    .req0_rdy   (req0_rdy),
    .resp0_msg  (resp0_msg),
    .resp0_val  (resp0_val),
    .resp0_rdy  (rs_rdy[0]),
    .req1_msg   (rq_msg[1]),
    .req1_val   (rq_val[1]),
    .req1_rdy   (req1_rdy),
    .resp1_msg  (resp1_msg),
    .resp1_val  (resp1_val),
    .resp1_rdy  (rs_rdy[1]),
    .memreq_msg (memreq_msg),
    .memreq_val (memreq_val),
    .memreq_rdy (memreq_rdy),
    .memresp_msg(memresp_msg),
    .memresp_val(memresp_val),
    .memresp_rdy(memresp_rdy)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: transaction-level view. The queue holds the port that
  // owns the single outstanding memory transaction (empty = idle).
  int          m_q [$];
  int          m_prio;
  int          m_cnt;

  // Stimulus / memory state
  bit               auto_req, drop_en, mem_rand, mreq_stall;
  int               raise_pct, rdy_pct, mem_dly, dly;
  logic [127:0]     mem_data;
  bit               pend;
  logic [REQ_W-1:0] pend_req;
  bit               wait_resp [2];
  int               grant_log [$];
  int               resp_cnt  [2];
  int               resp_seen [2];
  logic [RESP_W-1:0] last_resp [2];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [REQ_W-1:0] act, input logic [REQ_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [REQ_W-1:0] rand_req();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[REQ_W-1:0];
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int gl(input int i);
    return (grant_log.size() > i) ? grant_log[i] : -1;
  endfunction

  // Per-cycle comparison against the model (called at the falling edge).
  task automatic compare();
    int   g;
    int   own;
    logic gv;
    if (!reset) begin
      chk1("rst_memreq_val",  memreq_val,  1'b0);
      chk1("rst_req0_rdy",    req0_rdy,    1'b0);
      chk1("rst_req1_rdy",    req1_rdy,    1'b0);
      chk1("rst_resp0_val",   resp0_val,   1'b0);
      chk1("rst_resp1_val",   resp1_val,   1'b0);
      chk1("rst_memresp_rdy", memresp_rdy, 1'b0);
      m_q.delete();
      m_prio = 0;
      m_cnt  = 0;
      return;
    end
    chk_int("txn_cnt", int'(dut.r_txn_cnt), m_cnt);
    if (m_q.size() == 0) begin
      gv = rq_val[0] | rq_val[1];
      if (rq_val[0] && rq_val[1]) g = m_prio;
      else                        g = rq_val[1] ? 1 : 0;
      chk1("memreq_val", memreq_val, gv);
      if (gv) chkw("memreq_msg", memreq_msg, rq_msg[g]);
      chk1("req0_rdy", req0_rdy, gv && g == 0 && memreq_rdy);
      chk1("req1_rdy", req1_rdy, gv && g == 1 && memreq_rdy);
      chk1("resp0_val_idle", resp0_val, 1'b0);
      chk1("resp1_val_idle", resp1_val, 1'b0);
      chk1("memresp_rdy_idle", memresp_rdy, 1'b0);
      if (gv && memreq_rdy) m_q.push_back(g);
    end else begin
      own = m_q[0];
      chk1("memreq_val_wait", memreq_val, 1'b0);
      chk1("req0_rdy_wait", req0_rdy, 1'b0);
      chk1("req1_rdy_wait", req1_rdy, 1'b0);
      chk1("resp0_val", resp0_val, (own == 0) && memresp_val);
      chk1("resp1_val", resp1_val, (own == 1) && memresp_val);
      chk1("memresp_rdy", memresp_rdy, rs_rdy[own]);
      if (own == 0 && memresp_val) chkw("resp0_msg", {30'b0, resp0_msg}, {30'b0, memresp_msg});
      if (own == 1 && memresp_val) chkw("resp1_msg", {30'b0, resp1_msg}, {30'b0, memresp_msg});
      if (memresp_val && rs_rdy[own]) begin
        void'(m_q.pop_front());
        m_prio = 1 - own;
        m_cnt  = (m_cnt + 1) % 65536;
      end
    end
  endtask

  // One clock: compare and sample at the falling edge, then act as memory
  // and (optionally) as two random blocking caches just after the rising edge.
  task automatic cycle();
    bit sf [2];
    bit sr [2];
    bit msf, mrf;
    logic [REQ_W-1:0] mreq;
    @(negedge clk);
    compare();
    sf[0] = rq_val[0] & req0_rdy;
    sf[1] = rq_val[1] & req1_rdy;
    sr[0] = resp0_val & rs_rdy[0];
    sr[1] = resp1_val & rs_rdy[1];
    msf   = memreq_val & memreq_rdy;
    mreq  = memreq_msg;
    mrf   = memresp_val & memresp_rdy;
    if (sf[0]) grant_log.push_back(0);
    if (sf[1]) grant_log.push_back(1);
    if (resp0_val) resp_seen[0]++;
    if (resp1_val) resp_seen[1]++;
    if (sr[0]) begin resp_cnt[0]++; last_resp[0] = resp0_msg; end
    if (sr[1]) begin resp_cnt[1]++; last_resp[1] = resp1_msg; end
    @(posedge clk);
    #1;
    if (!reset) begin
      pend        = 1'b0;
      memresp_val = 1'b0;
    end else begin
      if (mrf) begin
        pend        = 1'b0;
        memresp_val = 1'b0;
      end
      if (msf) begin
        pend     = 1'b1;
        pend_req = mreq;
        dly      = mem_rand ? int'($urandom_range(0, 4)) : mem_dly;
      end else if (pend && !memresp_val) begin
        if (dly <= 0) begin
          memresp_val = 1'b1;
          memresp_msg = {pend_req[174:172], pend_req[171:164], 2'b00, pend_req[131:128],
                         mem_rand ? rand128() : mem_data};
        end else begin
          dly--;
        end
      end
    end
    memreq_rdy = mreq_stall ? 1'b0 : (mem_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    for (int p = 0; p < 2; p++) begin
      if (sf[p]) begin
        rq_val[p]    = 1'b0;
        wait_resp[p] = 1'b1;
      end
      if (sr[p] || !reset) wait_resp[p] = 1'b0;
      if (auto_req) begin
        if (!reset) begin
          rq_val[p] = 1'b0;
        end else if (!wait_resp[p] && !rq_val[p] && !sf[p]) begin
          if (int'($urandom_range(0, 99)) < raise_pct) begin
            rq_val[p] = 1'b1;
            rq_msg[p] = rand_req();
          end
        end else if (rq_val[p] && drop_en && $urandom_range(0, 15) == 0) begin
          rq_val[p] = 1'b0;
        end
        rs_rdy[p] = int'($urandom_range(0, 99)) < rdy_pct;
      end
    end
  endtask

  task automatic wait_idle(input int bound, input string nm);
    int k = 0;
    while ((m_q.size() != 0 || rq_val[0] || rq_val[1] || memresp_val) && k < bound) begin
      cycle();
      k++;
    end
    chk1({nm, "_done_in_time"}, k < bound, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset       = 1'b0;
    rq_val[0]   = 1'b0;  rq_val[1] = 1'b0;
    rs_rdy[0]   = 1'b1;  rs_rdy[1] = 1'b1;
    rq_msg[0]   = '0;    rq_msg[1] = '0;
    memreq_rdy  = 1'b1;
    memresp_val = 1'b0;
    memresp_msg = '0;
    auto_req = 0; drop_en = 0; mem_rand = 0; mreq_stall = 0;
    raise_pct = 0; rdy_pct = 100; mem_dly = 2; dly = 0;
    mem_data = {4{32'hdeadbeef}};
    pend = 0; pend_req = '0;
    wait_resp[0] = 0; wait_resp[1] = 0;
    resp_cnt[0] = 0; resp_cnt[1] = 0; resp_seen[0] = 0; resp_seen[1] = 0;
    last_resp[0] = '0; last_resp[1] = '0;
    m_prio = 0; m_cnt = 0;

    // Reset holds every handshake low even with both requesters active.
    rq_msg[0] = rand_req(); rq_msg[1] = rand_req();
    rq_val[0] = 1'b1; rq_val[1] = 1'b1;
    repeat (3) begin
      cycle();
      chk1("t1_memreq_val", memreq_val, 1'b0);
      chk1("t1_req0_rdy", req0_rdy, 1'b0);
      chk1("t1_req1_rdy", req1_rdy, 1'b0);
      chk1("t1_memresp_rdy", memresp_rdy, 1'b0);
    end
    reset = 1'b1;
    #1;
    chk1("t1_rel_memreq_val", memreq_val, 1'b1);
    chk1("t1_rel_req0_rdy", req0_rdy, 1'b1);
    chk1("t1_rel_req1_rdy", req1_rdy, 1'b0);
    chkw("t1_rel_memreq_msg", memreq_msg, rq_msg[0]);
    grant_log.delete();
    wait_idle(100, "t1");
    chk_int("t1_ngrants", grant_log.size(), 2);
    chk_int("t1_grant0", gl(0), 0);
    chk_int("t1_grant1", gl(1), 1);

    // Single requester on port 1, memory answering a few cycles later.
    resp_cnt[0] = 0; resp_cnt[1] = 0; resp_seen[0] = 0; resp_seen[1] = 0;
    rq_msg[1] = {3'd0, 8'h05, 32'h0000_1000, 4'd0, 128'd0};
    rq_val[1] = 1'b1;
    wait_idle(50, "t2");
    chk_int("t2_resp1_cnt", resp_cnt[1], 1);
    chk_int("t2_resp0_seen", resp_seen[0], 0);
    chkw("t2_resp1_msg", {30'b0, last_resp[1]},
         {30'b0, 3'd0, 8'h05, 2'd0, 4'd0, {4{32'hdeadbeef}}});
    chk_int("t2_txn_cnt", int'(dut.r_txn_cnt), 3);

    // Continuous contention alternates the grant.
    grant_log.delete();
    auto_req = 1; raise_pct = 100; drop_en = 0; rdy_pct = 100;
    k = 0;
    while (grant_log.size() < 4 && k < 200) begin cycle(); k++; end
    auto_req = 0;
    rq_val[0] = 1'b0; rq_val[1] = 1'b0;
    rs_rdy[0] = 1'b1; rs_rdy[1] = 1'b1;
    wait_idle(100, "t3");
    chk_int("t3_ngrants", grant_log.size(), 4);
    chk_int("t3_grant0", gl(0), 0);
    chk_int("t3_grant1", gl(1), 1);
    chk_int("t3_grant2", gl(2), 0);
    chk_int("t3_grant3", gl(3), 1);

    // Memory backpressure: grant stays on port 0 while port 1 arrives.
    grant_log.delete();
    mreq_stall = 1; memreq_rdy = 1'b0;
    rq_msg[0] = rand_req();
    rq_val[0] = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        rq_msg[1] = rand_req();
        rq_val[1] = 1'b1;
        #1;
      end
      chk1("t4_memreq_val", memreq_val, 1'b1);
      chkw("t4_memreq_msg", memreq_msg, rq_msg[0]);
      chk1("t4_req0_rdy", req0_rdy, 1'b0);
      chk1("t4_req1_rdy", req1_rdy, 1'b0);
      cycle();
    end
    mreq_stall = 0; memreq_rdy = 1'b1;
    wait_idle(100, "t4");
    chk_int("t4_ngrants", grant_log.size(), 2);
    chk_int("t4_grant0", gl(0), 0);
    chk_int("t4_grant1", gl(1), 1);

    // Response stall on port 0 keeps the arbiter locked.
    rs_rdy[0] = 1'b0;
    rq_msg[0] = rand_req();
    rq_val[0] = 1'b1;
    k = 0;
    while (!memresp_val && k < 30) begin cycle(); k++; end
    chk1("t5_resp_arrives", memresp_val, 1'b1);
    rq_msg[1] = rand_req();
    rq_val[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("t5_memresp_rdy", memresp_rdy, 1'b0);
      chk1("t5_resp0_val", resp0_val, 1'b1);
      chk1("t5_memreq_val", memreq_val, 1'b0);
      chk1("t5_req1_rdy", req1_rdy, 1'b0);
      cycle();
    end
    rs_rdy[0] = 1'b1;
    wait_idle(100, "t5");
    chk_int("t5_txn_cnt", int'(dut.r_txn_cnt), 11);

    // Mid-transaction reset with prio = 1 beforehand.
    rq_msg[0] = rand_req();
    rq_val[0] = 1'b1;
    wait_idle(50, "t6a");
    mem_dly = 6;
    rq_msg[0] = rand_req();
    rq_val[0] = 1'b1;
    k = 0;
    while (m_q.size() == 0 && k < 20) begin cycle(); k++; end
    cycle();
    reset = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    #1;
    chk1("t6_memreq_val", memreq_val, 1'b0);
    chk1("t6_memresp_rdy", memresp_rdy, 1'b0);
    chk_int("t6_txn_cnt_rst", int'(dut.r_txn_cnt), 0);
    rq_msg[0] = rand_req(); rq_msg[1] = rand_req();
    rq_val[0] = 1'b1; rq_val[1] = 1'b1;
    #1;
    chk1("t6_req0_rdy", req0_rdy, 1'b1);
    chk1("t6_req1_rdy", req1_rdy, 1'b0);
    rq_val[0] = 1'b0; rq_val[1] = 1'b0;
    cycle();
    mem_dly = 2;
    resp_cnt[0] = 0; resp_cnt[1] = 0;
    rq_msg[1] = {3'd1, 8'h2a, 32'h0000_2000, 4'd0, 128'h1234_5678};
    rq_val[1] = 1'b1;
    wait_idle(50, "t6b");
    chk_int("t6_resp1_cnt", resp_cnt[1], 1);
    chk_int("t6_txn_cnt", int'(dut.r_txn_cnt), 1);

    // Randomized traffic against the model.
    grant_log.delete();
    auto_req = 1; raise_pct = 50; drop_en = 1; rdy_pct = 75; mem_rand = 1;
    repeat (3000) cycle();
    auto_req = 0; mem_rand = 0;
    rq_val[0] = 1'b0; rq_val[1] = 1'b0;
    rs_rdy[0] = 1'b1; rs_rdy[1] = 1'b1;
    wait_idle(200, "t7");
    chk1("t7_activity", grant_log.size() > 10, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
